// File: rtl/spike_stim_pkg.sv
// Shared types for the spike stimulus player.
// Event record, FSM states and field widths.
package spike_stim_pkg;

  localparam int ADDR_W    = 8;
  localparam int TS_MAX_W  = 32;
  localparam int ROW_MAX_W = 8;

  typedef struct packed {
    logic [TS_MAX_W-1:0]  timestamp;
    logic [ROW_MAX_W-1:0] row;
    logic                 on_off;
    logic [ADDR_W-1:0]    address;
  } stim_event_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic int row_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous event FIFO; reset flushes it.
// Ports: push/din in, pop in, dout head, full/empty/count out.
module spike_event_fifo
  import spike_stim_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  stim_event_t              din,
  input  logic                     pop,
  output stim_event_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  stim_event_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_stimulus_player.sv
// Timestep-scheduled spike source feeding per-row stimulus.
// Ports: start/stop control, event push (valid/ready),
// per-row stim_valid/on_off/address, running, time_now,
// late_count, fifo_empty.
module spike_stimulus_player
  import spike_stim_pkg::*;
#(
  parameter int NUM_SYNAPSE_ROWS = 1,
  parameter int FIFO_DEPTH       = 16,
  parameter int TS_WIDTH         = 16,
  parameter int TICK_DIV         = 4,
  localparam int ROW_W           = row_w(NUM_SYNAPSE_ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [TS_WIDTH-1:0]                in_timestamp,
  input  logic [ROW_W-1:0]                   in_row,
  input  logic                               in_on_off,
  input  logic [ADDR_W-1:0]                  in_address,
  output logic [NUM_SYNAPSE_ROWS-1:0]        stim_valid,
  output logic [NUM_SYNAPSE_ROWS-1:0]        stim_on_off,
  output logic [ADDR_W*NUM_SYNAPSE_ROWS-1:0] stim_address,
  output logic                               running,
  output logic [TS_WIDTH-1:0]                time_now,
  output logic [7:0]                         late_count,
  output logic                               fifo_empty
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t                      state;
  state_t                      state_nx;
  logic [DIV_W-1:0]            div;
  stim_event_t                 din;
  stim_event_t                 head;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [TS_WIDTH-1:0]         diff;
  logic                        is_late;
  logic                        due;
  logic                        pop;
  logic                        row_ok;
  logic                        unused_bits;

  assign din.timestamp = TS_MAX_W'(in_timestamp);
  assign din.row       = ROW_MAX_W'(in_row);
  assign din.on_off    = in_on_off;
  assign din.address   = in_address;

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready    = !fifo_full;
  assign running     = (state == ST_RUN);
  assign unused_bits = ^{fifo_count, head};

  // Signed modular difference keeps the due test
  // correct across counter wrap within half-range.
  assign diff    = head.timestamp[TS_WIDTH-1:0] - time_now;
  assign is_late = diff[TS_WIDTH-1];
  assign due     = is_late || (diff == '0);
  assign pop     = running && !stop && !fifo_empty && due;
  assign row_ok  = int'(head.row) < NUM_SYNAPSE_ROWS;

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = ST_IDLE;
    end else if (start) begin
      state_nx = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      time_now <= '0;
    end else if (!stop) begin
      if (start) begin
        div      <= '0;
        time_now <= '0;
      end else if (running) begin
        if (div == DIV_LAST) begin
          div      <= '0;
          time_now <= time_now + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    stim_valid   <= '0;
    stim_on_off  <= '0;
    stim_address <= '0;
    if (!reset && pop) begin
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
        if (int'(head.row) == r) begin
          stim_valid[r]                 <= 1'b1;
          stim_on_off[r]                <= head.on_off;
          stim_address[r*ADDR_W +: ADDR_W] <= head.address;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      late_count <= '0;
    end else if (pop && row_ok && is_late
                 && late_count != 8'hFF) begin
      late_count <= late_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_spike_stimulus_player.sv
// Self-checking bench for spike_stimulus_player.
// Directed table, corner sequences, random vs model.
module tb_spike_stimulus_player;

  localparam int NR   = 3;
  localparam int DEP  = 16;
  localparam int TSW  = 5;
  localparam int TD   = 2;
  localparam int MOD  = 1 << TSW;
  localparam int HALF = 1 << (TSW - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TSW-1:0] in_timestamp = '0;
  logic [1:0]    in_row = '0;
  logic          in_on_off = 1'b0;
  logic [7:0]    in_address = '0;
  logic [NR-1:0] stim_valid;
  logic [NR-1:0] stim_on_off;
  logic [8*NR-1:0] stim_address;
  logic          running;
  logic [TSW-1:0] time_now;
  logic [7:0]    late_count;
  logic          fifo_empty;

  always #5 clk = ~clk;

  spike_stimulus_player #(
    .NUM_SYNAPSE_ROWS (NR),
    .FIFO_DEPTH       (DEP),
    .TS_WIDTH         (TSW),
    .TICK_DIV         (TD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_timestamp (in_timestamp),
    .in_row       (in_row),
    .in_on_off    (in_on_off),
    .in_address   (in_address),
    .stim_valid   (stim_valid),
    .stim_on_off  (stim_on_off),
    .stim_address (stim_address),
    .running      (running),
    .time_now     (time_now),
    .late_count   (late_count),
    .fifo_empty   (fifo_empty)
  );

  int total = 0;
  int bad = 0;
  int n_pulse = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of pending events and a
  // run-cycle count from which the timestep is derived.
  typedef struct {
    int ts;
    int row;
    bit on;
    int addr;
  } ev_t;

  ev_t         q[$];
  bit          m_run = 0;
  int          m_cycles = 0;
  int          m_late = 0;
  logic [NR-1:0]   e_valid = '0;
  logic [NR-1:0]   e_on = '0;
  logic [8*NR-1:0] e_addr = '0;

  function automatic int m_time();
    return (m_cycles / TD) % MOD;
  endfunction

  task automatic model_step();
    int now;
    int sz;
    int dd;
    ev_t e;
    if (reset) begin
      q.delete();
      m_run = 0;
      m_cycles = 0;
      m_late = 0;
      e_valid = '0;
      e_on = '0;
      e_addr = '0;
      return;
    end
    now = m_time();
    sz = q.size();
    e_valid = '0;
    e_on = '0;
    e_addr = '0;
    if (m_run && !stop && sz > 0) begin
      dd = (q[0].ts - now) & (MOD - 1);
      if (dd == 0 || dd >= HALF) begin
        e = q.pop_front();
        if (e.row < NR) begin
          e_valid[e.row] = 1'b1;
          e_on[e.row] = e.on;
          e_addr[e.row*8 +: 8] = 8'(e.addr);
          if (dd >= HALF && m_late < 255) m_late++;
        end
      end
    end
    if (in_valid && sz < DEP) begin
      e.ts = int'(in_timestamp);
      e.row = int'(in_row);
      e.on = in_on_off;
      e.addr = int'(in_address);
      q.push_back(e);
    end
    if (stop) m_run = 0;
    else if (start) begin
      m_run = 1;
      m_cycles = 0;
    end else if (m_run) m_cycles++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    n_pulse += $countones(stim_valid);
    chk("m_valid", 64'(stim_valid), 64'(e_valid));
    chk("m_on", 64'(stim_on_off), 64'(e_on));
    chk("m_addr", 64'(stim_address), 64'(e_addr));
    chk("m_run", 64'(running), 64'(m_run));
    chk("m_time", 64'(time_now), 64'(m_time()));
    chk("m_late", 64'(late_count), 64'(m_late));
    chk("m_empty", 64'(fifo_empty), 64'(q.size() == 0));
    chk("m_ready", 64'(in_ready), 64'(q.size() < DEP));
  endtask

  task automatic idle_in();
    start = 1'b0;
    stop = 1'b0;
    in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic push(input int ts, input int row,
                      input bit on, input int addr);
    in_valid = 1'b1;
    in_timestamp = TSW'(ts);
    in_row = 2'(row);
    in_on_off = on;
    in_address = 8'(addr);
  endtask

  typedef struct {
    bit st, sp, v;
    int ts, row;
    bit on;
    int addr;
    logic [2:0] x_valid, x_on;
    logic [23:0] x_addr;
    bit x_run;
    int x_time, x_late;
    bit x_empty;
  } vec_t;

  vec_t tbl[18];

  initial begin
    bit seen;
    int cnt;
    tbl[0]  = '{0,0,1, 2,1,1,'h55, 3'b000,3'b000,24'h0, 0,0,0,0};
    tbl[1]  = '{1,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,0,0,0};
    tbl[2]  = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,0,0,0};
    tbl[3]  = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,1,0,0};
    tbl[4]  = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,1,0,0};
    tbl[5]  = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,2,0,0};
    tbl[6]  = '{0,0,0, 0,0,0,0,     3'b010,3'b010,24'h005500, 1,2,0,1};
    tbl[7]  = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,3,0,1};
    tbl[8]  = '{0,0,1, 1,2,0,'hA3,  3'b000,3'b000,24'h0, 1,3,0,0};
    tbl[9]  = '{0,0,0, 0,0,0,0,     3'b100,3'b000,24'hA30000, 1,4,1,1};
    tbl[10] = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,4,1,1};
    tbl[11] = '{0,0,1, 5,3,1,'h11,  3'b000,3'b000,24'h0, 1,5,1,0};
    tbl[12] = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,5,1,1};
    tbl[13] = '{0,0,1, 9,0,1,'h0F,  3'b000,3'b000,24'h0, 1,6,1,0};
    tbl[14] = '{0,1,0, 0,0,0,0,     3'b000,3'b000,24'h0, 0,6,1,0};
    tbl[15] = '{0,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 0,6,1,0};
    tbl[16] = '{1,1,0, 0,0,0,0,     3'b000,3'b000,24'h0, 0,6,1,0};
    tbl[17] = '{1,0,0, 0,0,0,0,     3'b000,3'b000,24'h0, 1,0,1,0};

    reset = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 64'(stim_valid), 64'(0));
    chk("rst_addr", 64'(stim_address), 64'(0));
    chk("rst_run", 64'(running), 64'(0));
    chk("rst_time", 64'(time_now), 64'(0));
    chk("rst_late", 64'(late_count), 64'(0));
    chk("rst_empty", 64'(fifo_empty), 64'(1));
    chk("rst_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 18; i++) begin
      idle_in();
      start = tbl[i].st;
      stop = tbl[i].sp;
      if (tbl[i].v) push(tbl[i].ts, tbl[i].row,
                         tbl[i].on, tbl[i].addr);
      cyc();
      chk($sformatf("tbl%0d_valid", i),
          64'(stim_valid), 64'(tbl[i].x_valid));
      chk($sformatf("tbl%0d_on", i),
          64'(stim_on_off), 64'(tbl[i].x_on));
      chk($sformatf("tbl%0d_addr", i),
          64'(stim_address), 64'(tbl[i].x_addr));
      chk($sformatf("tbl%0d_run", i),
          64'(running), 64'(tbl[i].x_run));
      chk($sformatf("tbl%0d_time", i),
          64'(time_now), 64'(tbl[i].x_time));
      chk($sformatf("tbl%0d_late", i),
          64'(late_count), 64'(tbl[i].x_late));
      chk($sformatf("tbl%0d_empty", i),
          64'(fifo_empty), 64'(tbl[i].x_empty));
    end

    // Restarted run: ts=9 event must appear at time 9.
    idle_in();
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      cyc();
      if (stim_valid[0]) seen = 1;
    end
    chk("ctrl_seen", 64'(seen), 64'(1));
    chk("ctrl_addr", 64'(stim_address[7:0]), 64'(8'h0F));
    chk("ctrl_time", 64'(time_now), 64'(9));

    // Full FIFO while idle, then drain all 16.
    reset = 1'b1;
    cyc();
    idle_in();
    for (int i = 0; i < DEP; i++) begin
      push(10, i % 3, i[0], i + 1);
      cyc();
    end
    chk("full_ready", 64'(in_ready), 64'(0));
    push(10, 0, 1, 'hEE);
    cyc();
    chk("full_ready2", 64'(in_ready), 64'(0));
    chk("full_empty", 64'(fifo_empty), 64'(0));
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    n_pulse = 0;
    for (int k = 0; k < 200 && !fifo_empty; k++) cyc();
    cyc();
    chk("full_pulses", 64'(n_pulse), 64'(16));
    chk("full_drained", 64'(fifo_empty), 64'(1));

    // Wrap: ts=1 pushed at time 30 releases after wrap.
    reset = 1'b1;
    cyc();
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    for (int k = 0; k < 100 && m_time() != 30; k++) cyc();
    chk("wrap_reach30", 64'(time_now), 64'(30));
    push(1, 0, 1, 'h77);
    cyc();
    idle_in();
    seen = 0;
    cnt = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc();
      cnt++;
      if (stim_valid[0]) seen = 1;
    end
    chk("wrap_seen", 64'(seen), 64'(1));
    chk("wrap_time", 64'(time_now inside {5'd1, 5'd2}), 64'(1));
    chk("wrap_late", 64'(late_count), 64'(0));

    // Reset in the middle of a burst.
    reset = 1'b1;
    cyc();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      push(0, i % 3, 1, 'h30 + i);
      cyc();
    end
    idle_in();
    start = 1'b1;
    cyc();
    idle_in();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc();
      if (stim_valid != '0) seen = 1;
    end
    chk("burst_seen", 64'(seen), 64'(1));
    reset = 1'b1;
    cyc();
    idle_in();
    chk("mrst_valid", 64'(stim_valid), 64'(0));
    chk("mrst_addr", 64'(stim_address), 64'(0));
    chk("mrst_empty", 64'(fifo_empty), 64'(1));
    chk("mrst_run", 64'(running), 64'(0));

    // Randomized traffic against the model.
    start = 1'b1;
    cyc();
    for (int k = 0; k < 3000; k++) begin
      idle_in();
      start = ($urandom_range(0, 99) == 0);
      stop = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 2) == 0)
        push((m_time() + int'($urandom_range(0, 8)) - 2)
               & (MOD - 1),
             int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, 255)));
      if (!running && $urandom_range(0, 19) == 0)
        start = 1'b1;
      cyc();
    end
    idle_in();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
